// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the top level.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_cond.sv
// Combinational sign conditioning: operand magnitudes on the way in and
// sign restoration of the raw unsigned result on the way out.
module mdu_sign_cond #(
  parameter int WIDTH = 32
) (
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] abs_a_o,
  output logic [WIDTH-1:0] abs_b_o,
  output logic             a_neg_o,
  output logic             b_neg_o,
  input  logic             is_div_i,
  input  logic             neg_lo_i,
  input  logic             neg_hi_i,
  input  logic [WIDTH-1:0] raw_hi_i,
  input  logic [WIDTH-1:0] raw_lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  assign a_neg_o = sgn_i & a_i[WIDTH-1];
  assign b_neg_o = sgn_i & b_i[WIDTH-1];

  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign abs_a_o = a_neg_o ? -a_i : a_i;
  assign abs_b_o = b_neg_o ? -b_i : b_i;

  assign prod     = {raw_hi_i, raw_lo_i};
  assign prod_neg = -prod;

  always_comb begin
    hi_o = raw_hi_i;
    lo_o = raw_lo_i;
    if (is_div_i) begin
      // Quotient follows sign of a^b, remainder follows the dividend.
      lo_o = neg_lo_i ? -raw_lo_i : raw_lo_i;
      hi_o = neg_hi_i ? -raw_hi_i : raw_hi_i;
    end else if (neg_lo_i) begin
      {hi_o, lo_o} = prod_neg;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one result bit per cycle, shift-add multiply
// and restoring divide sharing a single WIDTH+1-bit adder/subtractor.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  op_e              op_in;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   add_x, add_y, add_sum;
  logic             add_sub;
  logic [WIDTH-1:0] acc_nx, wq_nx;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign op_in = op_e'(op);

  mdu_sign_cond #(.WIDTH(WIDTH)) u_sign_cond (
    .sgn_i    (op_is_signed(op_in)),
    .a_i      (a),
    .b_i      (b),
    .abs_a_o  (abs_a),
    .abs_b_o  (abs_b),
    .a_neg_o  (a_neg),
    .b_neg_o  (b_neg),
    .is_div_i (op_is_div(op_q)),
    .neg_lo_i (neg_lo_q),
    .neg_hi_i (neg_hi_q),
    .raw_hi_i (acc_nx),
    .raw_lo_i (wq_nx),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  // Shared adder: divide subtracts the divisor from the shifted remainder,
  // multiply conditionally adds the multiplicand to the upper accumulator.
  always_comb begin
    if (op_is_div(op_q)) begin
      add_x   = {acc_q, wq_q[WIDTH-1]};
      add_y   = {1'b0, opnd_q};
      add_sub = 1'b1;
    end else begin
      add_x   = {1'b0, acc_q};
      add_y   = wq_q[0] ? {1'b0, opnd_q} : '0;
      add_sub = 1'b0;
    end
  end

  assign add_sum = add_x + (add_y ^ {(WIDTH+1){add_sub}}) + {{WIDTH{1'b0}}, add_sub};

  always_comb begin
    if (op_is_div(op_q)) begin
      // Top bit set means the trial subtraction borrowed: restore.
      acc_nx = add_sum[WIDTH] ? add_x[WIDTH-1:0] : add_sum[WIDTH-1:0];
      wq_nx  = {wq_q[WIDTH-2:0], ~add_sum[WIDTH]};
    end else begin
      acc_nx = add_sum[WIDTH:1];
      wq_nx  = {add_sum[0], wq_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    wq_d     = wq_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d     = op_in;
          cnt_d    = '0;
          acc_d    = '0;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          state_d  = S_RUN;
          if (op_is_div(op_in)) begin
            wq_d   = abs_a;
            opnd_d = abs_b;
            if (b == '0) begin
              state_d = S_DONE;
              hi_d    = a;
              lo_d    = '1;
              dbz_d   = 1'b1;
            end
          end else begin
            wq_d   = abs_b;
            opnd_d = abs_a;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_nx;
        wq_d  = wq_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULTU;
      cnt_q    <= '0;
      acc_q    <= '0;
      wq_q     <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wq_q     <= wq_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32 with hand-computed results.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // lat counts rising edges from the start edge (inclusive) to the edge that raised done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #1;
    total_cnt++; if ({busy, done, div_by_zero} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {busy, done, div_by_zero}); else pass_cnt++;
    total_cnt++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo got %h exp 0", {hi, lo}); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_multu;
    int lat, bc;
    run_op(2'b00, 32'd50, 32'd100, lat, bc);
    total_cnt++; if (lat !== 33) $display("FAIL multu_latency got %0d exp 33", lat); else pass_cnt++;
    total_cnt++; if (bc !== 32) $display("FAIL multu_busy_cycles got %0d exp 32", bc); else pass_cnt++;
    total_cnt++; if (lo !== 32'd5000 || hi !== 32'd0) $display("FAIL multu_result got %h_%h exp 0_1388", hi, lo); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL multu_busy_at_done got %b exp 0", busy); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL done_pulse_width got %b exp 0", done); else pass_cnt++;
    repeat (3) @(posedge clk); #1;
    total_cnt++; if (lo !== 32'd5000 || hi !== 32'd0) $display("FAIL result_hold got %h_%h exp 0_1388", hi, lo); else pass_cnt++;
  endtask

  task automatic test_mult;
    int lat, bc;
    run_op(2'b01, -32'sd5, -32'sd10, lat, bc);
    total_cnt++; if (lo !== 32'd50 || hi !== 32'd0) $display("FAIL mult_neg_neg got %h_%h exp 0_32", hi, lo); else pass_cnt++;
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, lat, bc);
    total_cnt++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFF) $display("FAIL mult_m1_1 got %h_%h exp ffffffff_ffffffff", hi, lo); else pass_cnt++;
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, lat, bc);
    total_cnt++; if (lo !== 32'hFFFF_FFFE || hi !== 32'd1) $display("FAIL multu_big got %h_%h exp 1_fffffffe", hi, lo); else pass_cnt++;
  endtask

  task automatic test_div;
    int lat, bc;
    run_op(2'b11, -32'sd7, 32'd2, lat, bc);
    total_cnt++; if (lat !== 33) $display("FAIL div_latency got %0d exp 33", lat); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) $display("FAIL div_m7_2 got %h_%h exp ffffffff_fffffffd", hi, lo); else pass_cnt++;
    run_op(2'b10, 32'd7, 32'd2, lat, bc);
    total_cnt++; if (lo !== 32'd3 || hi !== 32'd1) $display("FAIL divu_7_2 got %h_%h exp 1_3", hi, lo); else pass_cnt++;
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    total_cnt++; if (lo !== 32'h8000_0000 || hi !== 32'd0 || div_by_zero !== 1'b0) $display("FAIL div_minneg_m1 got %h_%h dbz %b exp 0_80000000 dbz 0", hi, lo, div_by_zero); else pass_cnt++;
  endtask

  task automatic test_div_zero;
    int lat, bc;
    run_op(2'b10, 32'd5, 32'd0, lat, bc);
    total_cnt++; if (lat !== 1) $display("FAIL dbz_latency got %0d exp 1", lat); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd5 || div_by_zero !== 1'b1) $display("FAIL dbz_result got %h_%h dbz %b exp 5_ffffffff dbz 1", hi, lo, div_by_zero); else pass_cnt++;
    run_op(2'b00, 32'd3, 32'd4, lat, bc);
    total_cnt++; if (lo !== 32'd12 || hi !== 32'd0 || div_by_zero !== 1'b0) $display("FAIL dbz_clear got %h_%h dbz %b exp 0_c dbz 0", hi, lo, div_by_zero); else pass_cnt++;
  endtask

  task automatic test_ignore_midrun;
    int lat;
    @(negedge clk);
    op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 5) begin
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom;
      lat++;
    end
    total_cnt++; if (lat !== 33) $display("FAIL midrun_latency got %0d exp 33", lat); else pass_cnt++;
    total_cnt++; if (lo !== 32'd42 || hi !== 32'd0) $display("FAIL midrun_result got %h_%h exp 0_2a", hi, lo); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    run_op(2'b00, 32'd9, 32'd9, lat, bc);
    total_cnt++; if (lo !== 32'd81) $display("FAIL b2b_first got %h exp 51", lo); else pass_cnt++;
    // The negedge inside run_op falls within the DONE cycle, so start lands there.
    run_op(2'b10, 32'd100, 32'd7, lat, bc);
    total_cnt++; if (lat !== 33) $display("FAIL b2b_latency got %0d exp 33", lat); else pass_cnt++;
    total_cnt++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL b2b_second got %h_%h exp 2_e", hi, lo); else pass_cnt++;
  endtask

  task automatic test_reset_midrun;
    int lat, bc;
    logic done_seen;
    @(negedge clk);
    op = 2'b00; a = 32'd50; b = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    total_cnt++; if ({busy, done, div_by_zero} !== 3'b000 || {hi, lo} !== 64'd0) $display("FAIL async_reset got busy %b done %b hilo %h exp all zero", busy, done, {hi, lo}); else pass_cnt++;
    done_seen = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) done_seen = 1'b1;
    end
    start = 1'b0;
    total_cnt++; if (done_seen !== 1'b0) $display("FAIL reset_hold got activity %b exp 0", done_seen); else pass_cnt++;
    @(negedge clk); reset = 1'b0;
    run_op(2'b11, -32'sd20, 32'd3, lat, bc);
    total_cnt++; if (lat !== 33) $display("FAIL post_reset_latency got %0d exp 33", lat); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFF_FFFA || hi !== 32'hFFFF_FFFE) $display("FAIL post_reset_div got %h_%h exp fffffffe_fffffffa", hi, lo); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_midrun();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
